sum_response_checker: RTL and testbench

- Receiving end of the operand/sum stimulus path around the 8-bit adder.
- Consumes a stream of (a, b, observed o) triples over a valid/ready handshake and recomputes the expected sum a+b.
- Counts passes and failures, and logs mismatching triples into a small FIFO that the Python/VPI side drains as a reader.
- Sits in the top-level bench alongside the adder, replacing ad-hoc monitor printing with a checkable record.

---
 rtl/sum_response_checker_if.sv | 28 ++
 rtl/sum_response_checker.sv | 149 ++++++++++++++
 tb/tb_sum_response_checker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_response_checker_if.sv
// Operand/sum stream into the checker plus the mismatch-log read port.
// The slave modport is the checker's side; master is the driver/reader side.
interface sum_response_checker_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   in_o;

  logic             log_valid;
  logic             log_ready;
  logic [WIDTH-1:0] log_a;
  logic [WIDTH-1:0] log_b;
  logic [WIDTH:0]   log_o;
  logic [WIDTH:0]   log_exp;

  modport master (
    output in_valid, in_a, in_b, in_o, log_ready,
    input  in_ready, log_valid, log_a, log_b, log_o, log_exp
  );

  modport slave (
    input  in_valid, in_a, in_b, in_o, log_ready,
    output in_ready, log_valid, log_a, log_b, log_o, log_exp
  );
endinterface

// File: rtl/sum_response_checker.sv
// Recomputes a+b for each accepted (a, b, o) triple, keeps saturating
// pass/fail/drop statistics and logs mismatches into a small FWFT FIFO.
module sum_response_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  sum_response_checker_if.slave    bus,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);
  localparam int SW = WIDTH + 1;
  localparam int EW = 2 * WIDTH + 2 * SW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic             in_ready_reg;
  logic             accept;
  logic [SW-1:0]    exp_next;

  logic             s1_valid_reg;
  logic             s1_match_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [SW-1:0]    s1_o_reg;
  logic [SW-1:0]    s1_exp_reg;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head_reg;
  logic [EW-1:0]    wdata;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             drop;

  logic [CNT_W-1:0] pass_cnt_reg;
  logic [CNT_W-1:0] fail_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             overflow_reg;

  assign accept   = bus.in_valid & in_ready_reg;
  assign exp_next = {1'b0, bus.in_a} + {1'b0, bus.in_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
    end else begin
      in_ready_reg <= 1'b1;
      s1_valid_reg <= accept;
    end
  end

  // An unknown observed sum must land in the mismatch branch, so the flag
  // is only set on a definite equality.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_reg   <= bus.in_a;
      s1_b_reg   <= bus.in_b;
      s1_o_reg   <= bus.in_o;
      s1_exp_reg <= exp_next;
      if (bus.in_o == exp_next) s1_match_reg <= 1'b1;
      else                      s1_match_reg <= 1'b0;
    end
  end

  assign wdata    = {s1_a_reg, s1_b_reg, s1_o_reg, s1_exp_reg};
  assign push_req = s1_valid_reg & ~s1_match_reg;
  assign pop      = (count_reg != '0) & bus.log_ready;
  assign full     = (count_reg == FULL_CNT);
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push_ok && !pop)      count_next = count_reg + 1'b1;
    else if (!push_ok && pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Registered head: bypass the write data when the entry being pushed is
  // the one that becomes the head on this edge; hold when going empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (count_next != '0) begin
      if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_reg <= wdata;
      else                                        head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (s1_valid_reg) begin
      if (s1_match_reg) begin
        if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end else begin
        if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + 1'b1;
      end
      if (drop) begin
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.log_valid = (count_reg != '0);
  assign bus.log_a     = head_reg[EW-1 -: WIDTH];
  assign bus.log_b     = head_reg[2*SW+WIDTH-1 -: WIDTH];
  assign bus.log_o     = head_reg[2*SW-1 -: SW];
  assign bus.log_exp   = head_reg[SW-1:0];

  assign pass_cnt = pass_cnt_reg;
  assign fail_cnt = fail_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign overflow = overflow_reg;
endmodule

// File: tb/tb_sum_response_checker.sv
// Directed bench: stimulus pushes expected log entries into a queue, a
// negedge monitor compares every popped head; counters checked inline.
module tb_sum_response_checker;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_response_checker_if #(.WIDTH(W)) bus0 ();
  sum_response_checker_if #(.WIDTH(W)) bus1 ();

  logic [15:0] pass0, fail0, drop0;
  logic        ovf0;
  logic [3:0]  pass1, fail1, drop1;
  logic        ovf1;

  sum_response_checker #(.WIDTH(W), .DEPTH(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .pass_cnt(pass0), .fail_cnt(fail0), .drop_cnt(drop0), .overflow(ovf0)
  );

  sum_response_checker #(.WIDTH(W), .DEPTH(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .pass_cnt(pass1), .fail_cnt(fail1), .drop_cnt(drop1), .overflow(ovf1)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   o;
    logic [W:0]   e;
  } entry_t;

  entry_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid&ready.
  always @(negedge clk) begin
    entry_t got;
    entry_t want;
    if (bus0.log_valid && bus0.log_ready) begin
      got = {bus0.log_a, bus0.log_b, bus0.log_o, bus0.log_exp};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL log_pop: unexpected entry a=%0d b=%0d o=%0d exp=%0d",
                 got.a, got.b, got.o, got.e);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL log_pop: got a=%0d b=%0d o=%0d exp=%0d, expected a=%0d b=%0d o=%0d exp=%0d",
                   got.a, got.b, got.o, got.e, want.a, want.b, want.o, want.e);
        end else begin
          $display("[TB] pop a=%0d b=%0d o=%0d exp=%0d", got.a, got.b, got.o, got.e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int o, input bit logged);
    entry_t e;
    bus0.in_valid = 1'b1;
    bus0.in_a = a[W-1:0];
    bus0.in_b = b[W-1:0];
    bus0.in_o = o[W:0];
    if (logged) begin
      e.a = a[W-1:0];
      e.b = b[W-1:0];
      e.o = o[W:0];
      e.e = 9'(a + b);
      exp_q.push_back(e);
    end
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic drain(input int n);
    bus0.log_ready = 1'b1;
    repeat (n) tick();
    bus0.log_ready = 1'b0;
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_o = '0; bus0.log_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_o = '0; bus1.log_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", bus0.in_ready, 0);
    check("rst_log_valid", bus0.log_valid, 0);
    check("rst_pass_cnt", pass0, 0);
    check("rst_fail_cnt", fail0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_log_exp", bus0.log_exp, 0);
    rst = 1'b0;
    check("in_ready_before_edge", bus0.in_ready, 0);
    tick();
    check("in_ready_after_edge", bus0.in_ready, 1);

    // Simple pass, two-edge latency
    send(3, 4, 7, 0);
    check("pass_at_n", pass0, 0);
    tick();
    check("pass_at_n1", pass0, 1);
    check("no_log_on_pass", bus0.log_valid, 0);

    // Full-range pass then carry-lost mismatch, back to back
    send(255, 255, 510, 0);
    send(255, 1, 0, 1);
    tick();
    check("pass_255_255", pass0, 2);
    check("fail_carry", fail0, 1);
    check("log_valid_carry", bus0.log_valid, 1);
    check("head_a", bus0.log_a, 255);
    check("head_exp", bus0.log_exp, 256);
    drain(1);
    check("log_empty_after_pop", bus0.log_valid, 0);

    // Six mismatches into a depth-4 log with no reader
    do_reset();
    for (int i = 1; i <= 6; i++) send(i, i, 0, i <= 4);
    tick();
    check("burst_fail", fail0, 6);
    check("burst_drop", drop0, 2);
    check("burst_overflow", ovf0, 1);
    check("burst_pass", pass0, 0);
    drain(4);
    check("burst_drained", bus0.log_valid, 0);
    check("burst_queue_empty", exp_q.size(), 0);
    check("overflow_sticky", ovf0, 1);

    // Reset with three logged entries and a triple in flight
    for (int i = 0; i < 3; i++) send(40 + i, 1, 0, 1);
    send(1, 1, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_pass", pass0, 0);
    check("midrst_fail", fail0, 0);
    check("midrst_log_valid", bus0.log_valid, 0);
    check("midrst_overflow", ovf0, 0);
    check("midrst_log_a", bus0.log_a, 0);
    tick();
    tick();
    check("midrst_inflight_dropped", pass0, 0);

    // Full FIFO, simultaneous pop and push: nothing dropped
    do_reset();
    for (int k = 0; k < 4; k++) send(10 + k, 1, 0, 1);
    send(20, 1, 0, 1);
    bus0.log_ready = 1'b1;
    tick();
    bus0.log_ready = 1'b0;
    check("full_pp_drop", drop0, 0);
    check("full_pp_fail", fail0, 5);
    check("full_pp_overflow", ovf0, 0);
    check("full_pp_head_advanced", bus0.log_a, 11);
    drain(4);
    check("full_pp_drained", bus0.log_valid, 0);
    check("full_pp_queue_empty", exp_q.size(), 0);

    // Saturation on the narrow-counter instance
    for (int k = 0; k < 20; k++) begin
      bus1.in_valid = 1'b1;
      bus1.in_a = 8'(k);
      bus1.in_b = 8'(k + 1);
      bus1.in_o = 9'(2 * k + 1);
      tick();
      if (k == 14) check("sat_pass_mid", pass1, 14);
    end
    bus1.in_valid = 1'b0;
    tick();
    check("sat_pass", pass1, 15);
    check("sat_fail", fail1, 0);
    check("in_ready_held", bus1.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
